slc3_datapath_p: RTL
====================

SLC3_DATAPATH_P -- requirements
Module: slc3_datapath_p

Interface
REQ-001 Parameter WIDTH, default 16, shall set the data, bus and register width; legal values are 16 or greater; instruction fields are always decoded from IR[15:0].
REQ-002 Parameter PC_RESET, default 0, shall be the WIDTH-bit PC value after reset.
REQ-003 Clk  in  1  shall be the single clock; all state updates occur on its rising edge.
REQ-004 Reset  in  1  shall be the asynchronous, active-high reset.
REQ-005 LD_IR, LD_MDR, LD_MAR, LD_PC, LD_REG, LD_CC, LD_BEN  in  1 each  shall be the load enables.
REQ-006 GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  shall be the bus drive requests.
REQ-007 MIO_EN, ADDR1MUX, SR1MUX, SR2MUX, DRMUX  in  1 each  shall be the mux selects.
REQ-008 PCMUX, ADDR2MUX, ALUK  in  2 each  shall be the mux selects.
REQ-009 MDR_In  in  WIDTH  shall be the memory read data.
REQ-010 IR_Out, MDR_Out, MAR_Out, PC_Out  out  WIDTH each  shall be the register contents.
REQ-011 NZP  out  3  shall be the condition codes {N,Z,P}; BEN  out  1  shall be the branch-enable flag.
REQ-012 Bus_Conflict  out  1  shall be high combinationally whenever more than one Gate* input is high.

Function
REQ-013 Bus: a single Gate* high drives its source; with none high the bus is 0; with several high, fixed priority PC > MDR > ALU > MARMUX.
REQ-014 Address adder: ADDR1MUX 0 = PC, 1 = SR1 data; ADDR2MUX 00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]), 11 = sext(IR[10:0]); sum wraps modulo 2^WIDTH; this sum is the MARMUX source.
REQ-015 PCMUX 00 = PC+1 (wraps all-ones to 0), 01 = bus, 10 = adder sum, 11 = hold current PC.
REQ-016 Register file: 8 x WIDTH; two asynchronous read ports, one write port; LD_REG writes the bus to DR on the rising edge.
REQ-017 DRMUX 0 = IR[11:9], 1 = R7; SR1MUX 0 = IR[11:9], 1 = IR[8:6]; SR2 = IR[2:0].
REQ-018 SR2MUX 0 = SR2 data, 1 = sext(IR[4:0]).
REQ-019 ALUK 00 = A+B (wrap), 01 = A&B, 10 = ~A, 11 = pass A; A = SR1 data, B = SR2MUX output.
REQ-020 A register read in the cycle a write occurs shall return the old value; the new value is visible the following cycle.
REQ-021 LD_MDR loads MDR_In when MIO_EN=1, otherwise the bus; LD_IR and LD_MAR load the bus.
REQ-022 LD_CC loads NZP = 100 if bus[WIDTH-1] = 1, 010 if bus = 0, 001 otherwise.
REQ-023 LD_BEN loads BEN = |(IR[11:9] & NZP), using pre-edge IR and NZP.
REQ-024 Simultaneous loads in one cycle all sample the pre-edge bus and register values; no forwarding between them.
REQ-025 Registers without their load enable asserted shall hold their value.
REQ-026 Bus_Conflict shall be a diagnostic only; no state is blocked when it is high.

Reset
REQ-027 While Reset is high: IR, MDR and MAR are 0; PC = PC_RESET; all eight registers are 0; NZP = 010; BEN = 0; all load enables are ignored.
REQ-028 Reset asserted mid-operation shall take effect immediately, without waiting for Clk; the first load after deassertion occurs on the next rising edge.

Structure
REQ-029 Package slc3_pkg shall hold the enums for ALUK, PCMUX and ADDR2MUX, the NZP reset constant 3'b010, and the R7 index constant.
REQ-030 The register file shall be the sub-module slc3_regfile, parametrised by WIDTH.
REQ-031 The bus shall be a priority mux; no internal tri-states are used.

Verification
REQ-032 Reset release -> PC = PC_RESET, NZP = 010, BEN = 0; with PC_RESET = 16'h3000 and WIDTH = 16, PC_Out = 3000.
REQ-033 IR = 0x1283 (ADD R1,R2,R3), R2 = 5, R3 = 0xFFFA; GateALU, DRMUX = 0, SR1MUX = 1, SR2MUX = 0, LD_REG, LD_CC -> R1 = 0xFFFF and NZP = 100.
REQ-034 PC = 0x3000, IR[8:0] = 0x1FF; ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC -> PC = 0x2FFF; with PC = 0xFFFF, PCMUX = 00 -> PC = 0x0000.
REQ-035 GatePC and GateALU both high -> Bus_Conflict = 1 and the bus equals PC; LD_MAR -> MAR = PC.
REQ-036 LD_REG writes R4 = 0x00AA in cycle n while SR1 reads R4 -> ALU pass-A output is the old value in cycle n and 0x00AA in cycle n+1.
REQ-037 NZP = 001, IR[11:9] = 011, LD_BEN -> BEN = 1; then Reset pulsed between clock edges -> BEN = 0 and NZP = 010 without waiting for a clock edge.

Source files
------------

// File: rtl/slc3_pkg.sv
// SLC-3 datapath shared types: mux/ALU select encodings and fixed constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slc3_pkg;

    typedef enum logic [1:0] {
        ALUK_ADD  = 2'b00,
        ALUK_AND  = 2'b01,
        ALUK_NOT  = 2'b10,
        ALUK_PASS = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        PCMUX_INC  = 2'b00,
        PCMUX_BUS  = 2'b01,
        PCMUX_ADDR = 2'b10,
        PCMUX_HOLD = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'b00,
        ADDR2_OFF6  = 2'b01,
        ADDR2_OFF9  = 2'b10,
        ADDR2_OFF11 = 2'b11
    } addr2mux_e;

    localparam logic [2:0] NZP_RESET = 3'b010;
    localparam logic [2:0] R7_IDX    = 3'd7;

endpackage

// File: rtl/slc3_regfile.sv
// 8-entry register file, two asynchronous read ports, one synchronous write port.
// Latency: reads combinational; a write is visible from the cycle after the edge.
// Backpressure: none; a write happens whenever the write enable is high.
module slc3_regfile #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             we,
    input  logic [2:0]       dr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    output logic [WIDTH-1:0] sr1_data,
    output logic [WIDTH-1:0] sr2_data
);

    logic [WIDTH-1:0] regs [8];

    // Reads see the stored array only, so a same-cycle write returns the old value.
    assign sr1_data = regs[sr1];
    assign sr2_data = regs[sr2];

    // Clear all registers on reset; otherwise write the selected register when enabled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[dr] <= wdata;
        end
    end

endmodule

// File: rtl/slc3_datapath_p.sv
// SLC-3 datapath: bus priority mux, address adder, ALU, PC/IR/MDR/MAR/CC/BEN state and register file.
// Latency: all loads take effect on the next rising Clk; bus, ALU and Bus_Conflict are combinational.
// Backpressure: none; Bus_Conflict is diagnostic only and blocks no load.
module slc3_datapath_p
    import slc3_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_IR,
    input  logic             LD_MDR,
    input  logic             LD_MAR,
    input  logic             LD_PC,
    input  logic             LD_REG,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic             MIO_EN,
    input  logic             ADDR1MUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             DRMUX,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic [WIDTH-1:0] MDR_In,
    output logic [WIDTH-1:0] IR_Out,
    output logic [WIDTH-1:0] MDR_Out,
    output logic [WIDTH-1:0] MAR_Out,
    output logic [WIDTH-1:0] PC_Out,
    output logic [2:0]       NZP,
    output logic             BEN,
    output logic             Bus_Conflict
);

    logic [WIDTH-1:0] ir, mdr, mar, pc;
    logic [2:0]       nzp;
    logic             ben;

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] sr1_data, sr2_data;
    logic [WIDTH-1:0] alu_b, alu_out;
    logic [WIDTH-1:0] addr1, addr2, addr_sum;
    logic [WIDTH-1:0] pc_next;
    logic [2:0]       dr_idx, sr1_idx;
    logic [2:0]       nzp_next;

    // Sign-extended immediates; instruction fields always come from IR[15:0].
    logic [WIDTH-1:0] imm5, off6, off9, off11;
    assign imm5  = {{(WIDTH-5){ir[4]}},   ir[4:0]};
    assign off6  = {{(WIDTH-6){ir[5]}},   ir[5:0]};
    assign off9  = {{(WIDTH-9){ir[8]}},   ir[8:0]};
    assign off11 = {{(WIDTH-11){ir[10]}}, ir[10:0]};

    assign dr_idx  = DRMUX  ? R7_IDX   : ir[11:9];
    assign sr1_idx = SR1MUX ? ir[8:6]  : ir[11:9];

    slc3_regfile #(.WIDTH(WIDTH)) u_regfile (
        .Clk      (Clk),
        .Reset    (Reset),
        .we       (LD_REG),
        .dr       (dr_idx),
        .wdata    (bus),
        .sr1      (sr1_idx),
        .sr2      (ir[2:0]),
        .sr1_data (sr1_data),
        .sr2_data (sr2_data)
    );

    assign alu_b = SR2MUX ? imm5 : sr2_data;

    // ALU: A is always SR1 data, B is register or immediate.
    always_comb begin
        alu_out = sr1_data;
        case (ALUK)
            ALUK_ADD:  alu_out = sr1_data + alu_b;
            ALUK_AND:  alu_out = sr1_data & alu_b;
            ALUK_NOT:  alu_out = ~sr1_data;
            ALUK_PASS: alu_out = sr1_data;
            default:   alu_out = sr1_data;
        endcase
    end

    // Address adder base/offset selection; the sum feeds both PCMUX and the MARMUX gate.
    always_comb begin
        addr2 = '0;
        case (ADDR2MUX)
            ADDR2_ZERO:  addr2 = '0;
            ADDR2_OFF6:  addr2 = off6;
            ADDR2_OFF9:  addr2 = off9;
            ADDR2_OFF11: addr2 = off11;
            default:     addr2 = '0;
        endcase
    end

    assign addr1    = ADDR1MUX ? sr1_data : pc;
    assign addr_sum = addr1 + addr2;

    // Bus as a fixed-priority mux (PC > MDR > ALU > MARMUX), zero when undriven.
    always_comb begin
        bus = '0;
        if (GatePC)          bus = pc;
        else if (GateMDR)    bus = mdr;
        else if (GateALU)    bus = alu_out;
        else if (GateMARMUX) bus = addr_sum;
    end

    assign Bus_Conflict = (GatePC  & (GateMDR | GateALU | GateMARMUX)) |
                          (GateMDR & (GateALU | GateMARMUX)) |
                          (GateALU & GateMARMUX);

    // Next-PC selection.
    always_comb begin
        pc_next = pc;
        case (PCMUX)
            PCMUX_INC:  pc_next = pc + {{(WIDTH-1){1'b0}}, 1'b1};
            PCMUX_BUS:  pc_next = bus;
            PCMUX_ADDR: pc_next = addr_sum;
            PCMUX_HOLD: pc_next = pc;
            default:    pc_next = pc;
        endcase
    end

    // Condition codes derived from the current bus value.
    always_comb begin
        nzp_next = 3'b001;
        if (bus[WIDTH-1])    nzp_next = 3'b100;
        else if (bus == '0)  nzp_next = 3'b010;
    end

    // PC register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc <= PC_RESET;
        end else if (LD_PC) begin
            pc <= pc_next;
        end
    end

    // IR, MDR and MAR registers; MDR takes memory data or the bus.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir  <= '0;
            mdr <= '0;
            mar <= '0;
        end else begin
            if (LD_IR)  ir  <= bus;
            if (LD_MDR) mdr <= MIO_EN ? MDR_In : bus;
            if (LD_MAR) mar <= bus;
        end
    end

    // Condition codes and branch enable; BEN uses the pre-edge IR and NZP.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nzp <= NZP_RESET;
            ben <= 1'b0;
        end else begin
            if (LD_CC)  nzp <= nzp_next;
            if (LD_BEN) ben <= |(ir[11:9] & nzp);
        end
    end

    assign IR_Out  = ir;
    assign MDR_Out = mdr;
    assign MAR_Out = mar;
    assign PC_Out  = pc;
    assign NZP     = nzp;
    assign BEN     = ben;

endmodule
